// File: rtl/pio_led_pkg.sv
// Shared definitions for the LED PIO write arbiter.
//   op_t     : per-requester command code (write / set-bits / clear-bits / reserved)
//   ADDR_*   : PIO register addresses for data, set-bits and clear-bits
//   state_t  : arbiter FSM states
//   op_addr  : maps a command code to the PIO register it targets
package pio_led_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLR   = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_t;

  function automatic logic [2:0] op_addr(input op_t op);
    logic [2:0] a;
    a = ADDR_DATA;
    case (op)
      OP_SET:  a = ADDR_SET;
      OP_CLR:  a = ADDR_CLR;
      default: a = ADDR_DATA;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  IDX_W    highest-priority position for this round
//   grant     out NUM_REQ  one-hot grant (zero when no request)
//   grant_idx out IDX_W    binary index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam int unsigned N = NUM_REQ;

  logic             found;
  logic [IDX_W-1:0] pos;

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first set request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IDX_W'((32'(rr_ptr) + k) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/pio_led_write_arbiter.sv
// Shares one LED PIO slave among NUM_REQ requesters. Each accepted command becomes a
// single Avalon-MM write (data / set-bits / clear-bits register); a shadow copy of the
// LED register is kept for local readback.
//   clk, reset_n     clock, asynchronous active-low reset
//   req_valid/ready  per-requester command handshake (ready one-hot or zero, IDLE only)
//   req_op/req_data  per-requester op code (2 bits) and operand (DATA_W bits)
//   avm_*            Avalon-MM master towards the PIO, bus outputs registered
//   led_shadow       LED value after all completed writes
//   busy             high while a bus write is in progress
module pio_led_write_arbiter
  import pio_led_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [2*NUM_REQ-1:0]        req_op,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  output logic [2:0]                  avm_address,
  output logic                        avm_chipselect,
  output logic                        avm_write_n,
  output logic [31:0]                 avm_writedata,
  input  logic                        avm_waitrequest,
  output logic [DATA_W-1:0]           led_shadow,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr, grant_idx, lat_idx;
  logic [NUM_REQ-1:0]  grant;
  logic [1:0]          op_arr   [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];
  op_t                 sel_op, lat_op;
  logic [DATA_W-1:0]   sel_data, lat_data;
  logic                handshake;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]   = req_op[2*g +: 2];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    req_ready = (state == ST_IDLE) ? grant : '0;
    handshake = |(req_valid & req_ready);
    sel_op    = op_t'(op_arr[grant_idx]);
    sel_data  = data_arr[grant_idx];
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (handshake && sel_op != OP_RSVD) state_nxt = ST_WRITE;
      ST_WRITE: if (!avm_waitrequest)               state_nxt = ST_IDLE;
      default:                                      state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs are loaded at the handshake edge so they are already stable for the
  // whole first WRITE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr         <= '0;
      lat_op         <= OP_WRITE;
      lat_data       <= '0;
      lat_idx        <= '0;
      avm_address    <= ADDR_DATA;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      led_shadow     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            lat_op   <= sel_op;
            lat_data <= sel_data;
            lat_idx  <= grant_idx;
            if (sel_op == OP_RSVD) begin
              rr_ptr <= wrap_inc(grant_idx);
            end else begin
              avm_chipselect <= 1'b1;
              avm_write_n    <= 1'b0;
              avm_address    <= op_addr(sel_op);
              avm_writedata  <= 32'(sel_data);
            end
          end
        end
        ST_WRITE: begin
          if (!avm_waitrequest) begin
            case (lat_op)
              OP_SET:  led_shadow <= led_shadow | lat_data;
              OP_CLR:  led_shadow <= led_shadow & ~lat_data;
              default: led_shadow <= lat_data;
            endcase
            rr_ptr         <= wrap_inc(lat_idx);
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_led_write_arbiter.sv
module tb_pio_led_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [1:0]                op_a  [NUM_REQ];
  logic [7:0]                dat_a [NUM_REQ];
  logic [2*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [2:0]                avm_address;
  logic                      avm_chipselect;
  logic                      avm_write_n;
  logic [31:0]               avm_writedata;
  logic                      avm_waitrequest;
  logic [DATA_W-1:0]         led_shadow;
  logic                      busy;

  assign req_op   = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_data = {dat_a[3], dat_a[2], dat_a[1], dat_a[0]};

  pio_led_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_data        (req_data),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write_n     (avm_write_n),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .led_shadow      (led_shadow),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a command queue of one in flight, pointer kept as a plain integer.
  bit                 m_busy   = 1'b0;
  int                 m_ptr    = 0;
  int                 m_idx    = 0;
  int                 m_op     = 0;
  logic [7:0]         m_data   = '0;
  logic [7:0]         m_shadow = '0;
  logic [2:0]         m_addr   = '0;
  logic [31:0]        m_wdata  = '0;
  logic [NUM_REQ-1:0] hs_last  = '0;
  bit                 log_en   = 1'b0;
  int                 cyc      = 0;
  int                 glog[$];
  int                 gcyc[$];

  function automatic logic [2:0] exp_addr(input int op);
    return (op == 1) ? 3'd4 : (op == 2) ? 3'd5 : 3'd0;
  endfunction

  always @(negedge clk) begin
    int g;
    logic [NUM_REQ-1:0] exp_ready;
    cyc++;
    if (!reset_n) begin
      m_busy = 1'b0; m_ptr = 0; m_shadow = '0; m_addr = '0; m_wdata = '0;
      hs_last = '0;
    end else begin
      g = -1;
      exp_ready = '0;
      if (!m_busy)
        for (int k = 0; k < NUM_REQ; k++)
          if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("ready",   32'(req_ready),      32'(exp_ready));
      check("cs",      32'(avm_chipselect), 32'(m_busy));
      check("write_n", 32'(avm_write_n),    32'(!m_busy));
      check("addr",    32'(avm_address),    32'(m_addr));
      check("wdata",   avm_writedata,       m_wdata);
      check("shadow",  32'(led_shadow),     32'(m_shadow));
      check("busy",    32'(busy),           32'(m_busy));
      hs_last = req_valid & req_ready;
      if (log_en && g >= 0) begin glog.push_back(g); gcyc.push_back(cyc); end
      if (!m_busy && g >= 0) begin
        if (op_a[g] == 2'b11) m_ptr = (g + 1) % NUM_REQ;
        else begin
          m_busy = 1'b1; m_op = int'(op_a[g]); m_data = dat_a[g]; m_idx = g;
          m_addr = exp_addr(m_op); m_wdata = {24'd0, dat_a[g]};
        end
      end else if (m_busy && !avm_waitrequest) begin
        case (m_op)
          1:       m_shadow = m_shadow | m_data;
          2:       m_shadow = m_shadow & ~m_data;
          default: m_shadow = m_data;
        endcase
        m_ptr  = (m_idx + 1) % NUM_REQ;
        m_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [7:0] d);
    bit got;
    got = 1'b0;
    op_a[i] = op; dat_a[i] = d; req_valid[i] = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk); #1;
      if (req_ready[i]) got = 1'b1;
    end
    check("issue_ready", 32'(got), 32'd1);
    step();
    req_valid[i] = 1'b0;
  endtask

  task automatic bus_lit(input string n, input logic [2:0] a, input logic [31:0] wd);
    check({n, "_cs"},    32'(avm_chipselect), 32'd1);
    check({n, "_wn"},    32'(avm_write_n),    32'd0);
    check({n, "_addr"},  32'(avm_address),    32'(a));
    check({n, "_wdata"}, avm_writedata,       wd);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; req_valid = '0; avm_waitrequest = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin op_a[i] = 2'b00; dat_a[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs",     32'(avm_chipselect), 32'd0);
    check("rst_wn",     32'(avm_write_n),    32'd1);
    check("rst_addr",   32'(avm_address),    32'd0);
    check("rst_wdata",  avm_writedata,       32'd0);
    check("rst_shadow", 32'(led_shadow),     32'd0);
    check("rst_ready",  32'(req_ready),      32'd0);
    check("rst_busy",   32'(busy),           32'd0);
    reset_n = 1'b1;

    // Single write from requester 0
    issue(0, 2'b00, 8'hA5);
    @(negedge clk); #1; bus_lit("t1", 3'd0, 32'h0000_00A5);
    step(); @(negedge clk); #1;
    check("t1_shadow", 32'(led_shadow), 32'hA5);
    check("t1_cs_off", 32'(avm_chipselect), 32'd0);
    step();

    // Set then clear
    issue(1, 2'b01, 8'h0F);
    @(negedge clk); #1; bus_lit("t2s", 3'd4, 32'h0000_000F);
    step(); @(negedge clk); #1; check("t2_shadow_set", 32'(led_shadow), 32'hAF);
    step();
    issue(2, 2'b10, 8'h81);
    @(negedge clk); #1; bus_lit("t2c", 3'd5, 32'h0000_0081);
    step(); @(negedge clk); #1; check("t2_shadow_clr", 32'(led_shadow), 32'h2E);
    step();

    // Reserved op from requester 3: accepted, no bus cycle, pointer wraps to 0
    issue(3, 2'b11, 8'hFF);
    @(negedge clk); #1;
    check("t5_cs",     32'(avm_chipselect), 32'd0);
    check("t5_busy",   32'(busy),           32'd0);
    check("t5_shadow", 32'(led_shadow),     32'h2E);
    step();

    // All requesters valid: strict rotation from 0, one write every 2 cycles
    glog.delete(); gcyc.delete(); log_en = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin op_a[i] = 2'b00; dat_a[i] = 8'(8'h10 + i); end
    req_valid = '1;
    for (int c = 0; c < 40 && glog.size() < 5; c++) begin @(negedge clk); #1; end
    check("t3_count", 32'(glog.size()), 32'd5);
    step();
    req_valid = '0; log_en = 1'b0;
    for (int k = 0; k < 5 && k < glog.size(); k++) check("t3_order", 32'(glog[k]), 32'(k % 4));
    for (int k = 1; k < 5 && k < gcyc.size(); k++) check("t3_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd2);
    step();

    // Waitrequest held 3 cycles: bus stable 4 cycles, no new grant, late shadow update
    avm_waitrequest = 1'b1;
    issue(0, 2'b00, 8'h3C);
    op_a[1] = 2'b01; dat_a[1] = 8'h01; req_valid[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) avm_waitrequest = 1'b0;
      @(negedge clk); #1;
      bus_lit("t4", 3'd0, 32'h0000_003C);
      check("t4_ready", 32'(req_ready), 32'd0);
      check("t4_shadow_hold", 32'(led_shadow), 32'h10);
      step();
    end
    @(negedge clk); #1;
    check("t4_shadow", 32'(led_shadow), 32'h3C);
    check("t4_next_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid[1] = 1'b0;
    step();

    // Asynchronous reset mid-write, then a normal command
    issue(2, 2'b01, 8'h80);
    avm_waitrequest = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("t6_cs",     32'(avm_chipselect), 32'd0);
    check("t6_wn",     32'(avm_write_n),    32'd1);
    check("t6_shadow", 32'(led_shadow),     32'd0);
    check("t6_busy",   32'(busy),           32'd0);
    avm_waitrequest = 1'b0;
    step(); step();
    reset_n = 1'b1;
    issue(1, 2'b00, 8'h5A);
    @(negedge clk); #1; bus_lit("t6n", 3'd0, 32'h0000_005A);
    step(); @(negedge clk); #1; check("t6_shadow_after", 32'(led_shadow), 32'h5A);
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      if (c == 400) reset_n = 1'b0;
      if (c == 402) reset_n = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && hs_last[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(19) == 0) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(2) == 0) begin
          op_a[i]  = ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(2));
          dat_a[i] = 8'($urandom);
          req_valid[i] = 1'b1;
        end
      end
      avm_waitrequest = ($urandom_range(3) == 0);
      step();
    end
    req_valid = '0; avm_waitrequest = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
